// File: rtl/hilo_pkg.sv
// Shared op encodings and FSM state type for the HI/LO special-register unit.
package hilo_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP     = 3'd0;
    localparam logic [OP_W-1:0] OP_WR_HI   = 3'd1;
    localparam logic [OP_W-1:0] OP_WR_LO   = 3'd2;
    localparam logic [OP_W-1:0] OP_WR_BOTH = 3'd3;
    localparam logic [OP_W-1:0] OP_ACC_ADD = 3'd4;
    localparam logic [OP_W-1:0] OP_ACC_SUB = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2
    } hilo_state_e;

endpackage

// File: rtl/hilo_half_adder.sv
// DW-bit adder with optional inversion of the second operand and carry in/out;
// shared by the low and high halves of a multi-cycle accumulate.
module hilo_half_adder #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          inv_i,
    input  logic          cin_i,
    output logic [DW-1:0] sum_o,
    output logic          cout_o
);

    logic [DW:0] full;

    assign full   = {1'b0, a_i} + {1'b0, b_i ^ {DW{inv_i}}} + {{DW{1'b0}}, cin_i};
    assign sum_o  = full[DW-1:0];
    assign cout_o = full[DW];

endmodule

// File: rtl/hilo_acc_unit.sv
// HI/LO register pair with forwarded direct writes and a two-stage split-carry
// accumulate. Define HILO_ACC_SAT_EN for signed saturation and the sat_o pulse.
module hilo_acc_unit
    import hilo_pkg::*;
#(
    parameter int          DW     = 32,
    parameter logic [DW-1:0] RST_HI = '0,
    parameter logic [DW-1:0] RST_LO = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [DW-1:0]   req_hi,
    input  logic [DW-1:0]   req_lo,
    input  logic            flush,
    output logic [DW-1:0]   hi_o,
    output logic [DW-1:0]   lo_o,
    output logic            busy
`ifdef HILO_ACC_SAT_EN
    ,
    output logic            sat_o
`endif
);

    // Handshake: a request transfers on a rising edge where req_valid & req_ready
    // & ~flush; req_ready depends only on state, and a refused request must be held.
    hilo_state_e state_q, state_d;
    logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DW-1:0] opnd_hi_q, opnd_hi_d, opnd_lo_q, opnd_lo_d;
    logic [DW-1:0] lo_tmp_q, lo_tmp_d;
    logic          sub_q, sub_d, c_q, c_d;
    logic          accept, fwd_hi, fwd_lo;
    logic [DW-1:0] add_a, add_b, add_sum;
    logic          add_cin, add_cout;
`ifdef HILO_ACC_SAT_EN
    logic          sat_q, sat_d, ovf, a_sign;
`endif

    assign accept = req_valid & (state_q == IDLE) & ~flush & ~rst;
    assign fwd_hi = accept & ((req_op == OP_WR_HI) | (req_op == OP_WR_BOTH));
    assign fwd_lo = accept & ((req_op == OP_WR_LO) | (req_op == OP_WR_BOTH));

    // The single adder serves the low half in ACC_LO and the high half otherwise.
    assign add_a   = (state_q == ACC_LO) ? lo_q      : hi_q;
    assign add_b   = (state_q == ACC_LO) ? opnd_lo_q : opnd_hi_q;
    assign add_cin = (state_q == ACC_LO) ? sub_q     : c_q;

    hilo_half_adder #(.DW(DW)) u_adder (
        .a_i    (add_a),
        .b_i    (add_b),
        .inv_i  (sub_q),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

`ifdef HILO_ACC_SAT_EN
    // Signed overflow of the full-width result: same-signed effective operands,
    // result sign differs from the accumulator sign.
    assign a_sign = hi_q[DW-1];
    assign ovf    = (a_sign == (opnd_hi_q[DW-1] ^ sub_q)) && (add_sum[DW-1] != a_sign);
`endif

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_hi_d = opnd_hi_q;
        opnd_lo_d = opnd_lo_q;
        lo_tmp_d  = lo_tmp_q;
        sub_d     = sub_q;
        c_d       = c_q;
`ifdef HILO_ACC_SAT_EN
        sat_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (req_op)
                        OP_WR_HI:   hi_d = req_hi;
                        OP_WR_LO:   lo_d = req_lo;
                        OP_WR_BOTH: begin
                            hi_d = req_hi;
                            lo_d = req_lo;
                        end
                        OP_ACC_ADD, OP_ACC_SUB: begin
                            opnd_hi_d = req_hi;
                            opnd_lo_d = req_lo;
                            sub_d     = (req_op == OP_ACC_SUB);
                            state_d   = ACC_LO;
                        end
                        default: ;
                    endcase
                end
            end
            ACC_LO: begin
                state_d = IDLE;
                if (!flush) begin
                    lo_tmp_d = add_sum;
                    c_d      = add_cout;
                    state_d  = ACC_HI;
                end
            end
            ACC_HI: begin
                state_d = IDLE;
                if (!flush) begin
                    hi_d = add_sum;
                    lo_d = lo_tmp_q;
`ifdef HILO_ACC_SAT_EN
                    if (ovf) begin
                        hi_d  = a_sign ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
                        lo_d  = a_sign ? {DW{1'b0}} : {DW{1'b1}};
                        sat_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hi_q      <= RST_HI;
            lo_q      <= RST_LO;
            opnd_hi_q <= '0;
            opnd_lo_q <= '0;
            lo_tmp_q  <= '0;
            sub_q     <= 1'b0;
            c_q       <= 1'b0;
`ifdef HILO_ACC_SAT_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opnd_hi_q <= opnd_hi_d;
            opnd_lo_q <= opnd_lo_d;
            lo_tmp_q  <= lo_tmp_d;
            sub_q     <= sub_d;
            c_q       <= c_d;
`ifdef HILO_ACC_SAT_EN
            sat_q     <= sat_d;
`endif
        end
    end

    // Reset forces the reset-cycle view even before the first edge has landed.
    assign req_ready = rst | (state_q == IDLE);
    assign busy      = ~rst & (state_q != IDLE);
    assign hi_o      = rst ? RST_HI : (fwd_hi ? req_hi : hi_q);
    assign lo_o      = rst ? RST_LO : (fwd_lo ? req_lo : lo_q);
`ifdef HILO_ACC_SAT_EN
    assign sat_o     = ~rst & sat_q;
`endif

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Directed bench for hilo_acc_unit: direct writes with forwarding, accumulates,
// flush, reset abort and (with HILO_ACC_SAT_EN) saturation.
module tb_hilo_acc_unit;
    import hilo_pkg::*;

    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [OP_W-1:0] req_op;
    logic [DW-1:0]   req_hi;
    logic [DW-1:0]   req_lo;
    logic            flush;
    logic [DW-1:0]   hi_o;
    logic [DW-1:0]   lo_o;
    logic            busy;
`ifdef HILO_ACC_SAT_EN
    logic            sat_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    hilo_acc_unit #(.DW(DW), .RST_HI('0), .RST_LO('0)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_hi    (req_hi),
        .req_lo    (req_lo),
        .flush     (flush),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .busy      (busy)
`ifdef HILO_ACC_SAT_EN
        ,
        .sat_o     (sat_o)
`endif
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [OP_W-1:0] op, input logic [DW-1:0] h, input logic [DW-1:0] l);
        req_valid = 1'b1;
        req_op    = op;
        req_hi    = h;
        req_lo    = l;
    endtask

    task automatic idle_in();
        req_valid = 1'b0;
        req_op    = OP_NOP;
    endtask

    task automatic chk_out(input string tag, input logic [DW-1:0] eh, input logic [DW-1:0] el);
        check({tag, "_hi"}, {32'b0, hi_o}, {32'b0, eh});
        check({tag, "_lo"}, {32'b0, lo_o}, {32'b0, el});
    endtask

    task automatic chk_hs(input string tag, input logic erdy, input logic ebusy);
        check({tag, "_ready"}, {63'b0, req_ready}, {63'b0, erdy});
        check({tag, "_busy"}, {63'b0, busy}, {63'b0, ebusy});
    endtask

    task automatic wr_both(input logic [DW-1:0] h, input logic [DW-1:0] l);
        drive(OP_WR_BOTH, h, l);
        tick();
        idle_in();
        #1;
    endtask

    // Full accumulate: accept, two in-flight cycles showing old value, then commit.
    task automatic acc(input string tag, input logic [OP_W-1:0] op,
                       input logic [DW-1:0] h, input logic [DW-1:0] l,
                       input logic [DW-1:0] oh, input logic [DW-1:0] ol,
                       input logic [DW-1:0] nh, input logic [DW-1:0] nl);
        drive(op, h, l);
        #1;
        chk_out({tag, "_acc"}, oh, ol);
        chk_hs({tag, "_acc"}, 1'b1, 1'b0);
        tick();
        idle_in();
        #1;
        chk_hs({tag, "_s1"}, 1'b0, 1'b1);
        chk_out({tag, "_s1"}, oh, ol);
        tick();
        chk_hs({tag, "_s2"}, 1'b0, 1'b1);
        chk_out({tag, "_s2"}, oh, ol);
        tick();
        chk_hs({tag, "_done"}, 1'b1, 1'b0);
        chk_out({tag, "_done"}, nh, nl);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = OP_NOP; req_hi = '0; req_lo = '0;
        tick();
        chk_out("rst_cycle", 32'h0, 32'h0);
        chk_hs("rst_cycle", 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("post_rst", 32'h0, 32'h0);
        chk_hs("post_rst", 1'b1, 1'b0);

        // direct writes with write-first forwarding
        drive(OP_WR_BOTH, 32'h1234, 32'h5678);
        #1;
        chk_out("wr_both_fwd", 32'h1234, 32'h5678);
        tick();
        idle_in();
        #1;
        chk_out("wr_both_reg", 32'h1234, 32'h5678);

        drive(OP_WR_LO, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        #1;
        chk_out("wr_lo_fwd", 32'h1234, 32'hFFFF_FFFF);
        tick();
        idle_in();
        #1;
        chk_out("wr_lo_reg", 32'h1234, 32'hFFFF_FFFF);

        drive(OP_WR_HI, 32'h0, 32'hAAAA_AAAA);
        #1;
        chk_out("wr_hi_fwd", 32'h0, 32'hFFFF_FFFF);
        tick();
        idle_in();
        #1;
        chk_out("wr_hi_reg", 32'h0, 32'hFFFF_FFFF);

        // accumulates: carry out of LO, borrow through both halves, mixed carry
        acc("add_carry", OP_ACC_ADD, 32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0);
        wr_both(32'h0, 32'h0);
        acc("sub_wrap", OP_ACC_SUB, 32'h0, 32'h1, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wr_both(32'h1, 32'h0);
        acc("sub_borrow", OP_ACC_SUB, 32'h0, 32'h1, 32'h1, 32'h0, 32'h0, 32'hFFFF_FFFF);
        acc("add_mixed", OP_ACC_ADD, 32'h1234_5678, 32'h9ABC_DEF0,
            32'h0, 32'hFFFF_FFFF, 32'h1234_5679, 32'h9ABC_DEEF);

        // flush in ACC_HI drops the commit
        drive(OP_ACC_ADD, 32'h5, 32'h5);
        tick();
        idle_in();
        tick();
        flush = 1'b1;
        #1;
        chk_hs("flush_hi_inflight", 1'b0, 1'b1);
        tick();
        flush = 1'b0;
        #1;
        chk_hs("flush_hi_after", 1'b1, 1'b0);
        chk_out("flush_hi_after", 32'h1234_5679, 32'h9ABC_DEEF);
        tick();
        chk_out("flush_hi_later", 32'h1234_5679, 32'h9ABC_DEEF);

        // flush in ACC_LO
        drive(OP_ACC_SUB, 32'h7, 32'h7);
        tick();
        idle_in();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk_hs("flush_lo_after", 1'b1, 1'b0);
        tick();
        tick();
        chk_out("flush_lo_later", 32'h1234_5679, 32'h9ABC_DEEF);

        // flush in IDLE blocks acceptance and forwarding
        flush = 1'b1;
        drive(OP_WR_BOTH, 32'hAAAA, 32'hBBBB);
        #1;
        chk_out("flush_idle_fwd", 32'h1234_5679, 32'h9ABC_DEEF);
        tick();
        idle_in();
        flush = 1'b0;
        #1;
        chk_out("flush_idle_reg", 32'h1234_5679, 32'h9ABC_DEEF);

        // op 6 is a NOP
        drive(3'd6, 32'h1, 32'h1);
        #1;
        chk_out("op6_fwd", 32'h1234_5679, 32'h9ABC_DEEF);
        tick();
        idle_in();
        #1;
        chk_out("op6_reg", 32'h1234_5679, 32'h9ABC_DEEF);
        chk_hs("op6", 1'b1, 1'b0);

        // a write offered while busy is ignored and not forwarded
        drive(OP_ACC_ADD, 32'h0, 32'h1);
        tick();
        drive(OP_WR_BOTH, 32'h0, 32'h0);
        #1;
        chk_out("busy_wr_fwd", 32'h1234_5679, 32'h9ABC_DEEF);
        tick();
        idle_in();
        tick();
        chk_out("busy_wr_done", 32'h1234_5679, 32'h9ABC_DEF0);

        // reset mid-accumulate discards the operation
        drive(OP_ACC_ADD, 32'h0, 32'h1);
        tick();
        idle_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk_out("rst_mid", 32'h0, 32'h0);
        chk_hs("rst_mid", 1'b1, 1'b0);
        tick();
        tick();
        chk_out("rst_mid_later", 32'h0, 32'h0);

        // signed overflow at the top of the range, both directions
        wr_both(32'h7FFF_FFFF, 32'hFFFF_FFFF);
`ifdef HILO_ACC_SAT_EN
        acc("sat_pos", OP_ACC_ADD, 32'h0, 32'h1, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
            32'h7FFF_FFFF, 32'hFFFF_FFFF);
        check("sat_pos_pulse", {63'b0, sat_o}, 64'd1);
        tick();
        check("sat_pos_clear", {63'b0, sat_o}, 64'd0);
        wr_both(32'h8000_0000, 32'h0);
        acc("sat_neg", OP_ACC_SUB, 32'h0, 32'h1, 32'h8000_0000, 32'h0,
            32'h8000_0000, 32'h0);
        check("sat_neg_pulse", {63'b0, sat_o}, 64'd1);
        wr_both(32'h1, 32'h0);
        acc("nosat", OP_ACC_ADD, 32'h0, 32'h1, 32'h1, 32'h0, 32'h1, 32'h1);
        check("nosat_pulse", {63'b0, sat_o}, 64'd0);
`else
        acc("wrap_pos", OP_ACC_ADD, 32'h0, 32'h1, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
            32'h8000_0000, 32'h0);
        wr_both(32'h8000_0000, 32'h0);
        acc("wrap_neg", OP_ACC_SUB, 32'h0, 32'h1, 32'h8000_0000, 32'h0,
            32'h7FFF_FFFF, 32'hFFFF_FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
